// File: rtl/dog_pyramid_diff.sv
// Difference-of-Gaussian stage: turns NUM_SCALES co-located Gaussian pixels
// into NUM_SCALES-1 DoG lanes through a fixed 2-cycle pipeline. It also keeps
// a per-lane running maximum magnitude and reports it once per frame.
module dog_pyramid_diff #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_SCALES = 5,
  parameter int unsigned SB_W       = 1
) (
  input  logic                                    clk,
  input  logic                                    irst_n,
  input  logic                                    ivalid,
  input  logic [NUM_SCALES*PIX_W-1:0]             idata,
  input  logic [SB_W-1:0]                         isb,
  input  logic                                    isof,
  input  logic [1:0]                              imode,
  output logic                                    ovalid,
  output logic [(NUM_SCALES-1)*(PIX_W+1)-1:0]     odata,
  output logic [SB_W-1:0]                         osb,
  output logic                                    osof,
  output logic [(NUM_SCALES-1)*PIX_W-1:0]         omax,
  output logic                                    omax_valid
);

  localparam int unsigned L  = NUM_SCALES - 1;
  localparam int unsigned LW = PIX_W + 1;

  typedef enum logic [1:0] {
    MODE_CLAMP  = 2'd0,
    MODE_ABS    = 2'd1,
    MODE_SIGNED = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Stage-1 registers
  logic [NUM_SCALES*PIX_W-1:0] data1_q;
  logic [SB_W-1:0]             sb1_q;
  logic                        sof1_q;
  mode_e                       mode1_q;
  logic                        v1_q;

  // Stage-2 / output registers
  logic [L*LW-1:0]             odata_q;
  logic [SB_W-1:0]             osb_q;
  logic                        osof_q;
  logic                        ovalid_q;

  // Frame statistics
  logic [L*PIX_W-1:0]          acc_q,  acc_d;
  logic [L*PIX_W-1:0]          omax_q, omax_d;
  logic                        omax_valid_q, omax_valid_d;
  logic                        frame_seen_q, frame_seen_d;

  // Combinational lane results
  logic [L*LW-1:0]             lanes_d;
  logic [L*PIX_W-1:0]          mag_d;

  // Stage 1: capture the pixel, its sideband and its mode together
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      data1_q <= '0;
      sb1_q   <= '0;
      sof1_q  <= 1'b0;
      mode1_q <= MODE_CLAMP;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= ivalid;
      if (ivalid) begin
        data1_q <= idata;
        sb1_q   <= isb;
        sof1_q  <= isof;
        mode1_q <= mode_e'(imode);
      end
    end
  end

  // Per-lane difference, output formatting and magnitude
  always_comb begin : lane_calc
    logic [PIX_W:0] ga;
    logic [PIX_W:0] gb;
    logic [PIX_W:0] diff;
    logic [PIX_W:0] absd;
    logic [PIX_W:0] clamp;
    logic [PIX_W:0] lane;
    logic           gt;
    lanes_d = '0;
    mag_d   = '0;
    ga      = '0;
    gb      = '0;
    diff    = '0;
    absd    = '0;
    clamp   = '0;
    lane    = '0;
    gt      = 1'b0;
    for (int unsigned k = 0; k < L; k++) begin
      ga    = {1'b0, data1_q[k*PIX_W +: PIX_W]};
      gb    = {1'b0, data1_q[(k+1)*PIX_W +: PIX_W]};
      gt    = (ga > gb);
      diff  = ga - gb;
      absd  = gt ? diff : (gb - ga);
      clamp = gt ? diff : '0;
      case (mode1_q)
        MODE_ABS:    lane = absd;
        MODE_SIGNED: lane = diff;
        default:     lane = clamp;
      endcase
      lanes_d[k*LW +: LW] = lane;
      // Magnitude follows the clamp rule in modes 0/3, |D| otherwise
      if (mode1_q == MODE_ABS || mode1_q == MODE_SIGNED)
        mag_d[k*PIX_W +: PIX_W] = absd[PIX_W-1:0];
      else
        mag_d[k*PIX_W +: PIX_W] = clamp[PIX_W-1:0];
    end
  end

  // Stage 2: register lane results and align sideband/sof with them
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      odata_q  <= '0;
      osb_q    <= '0;
      osof_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      ovalid_q <= v1_q;
      if (v1_q) begin
        odata_q <= lanes_d;
        osb_q   <= sb1_q;
        osof_q  <= sof1_q;
      end
    end
  end

  // Frame statistics next state: a sof restarts the accumulator from the
  // current pixel and, once a frame has been seen, publishes the old max
  always_comb begin
    acc_d        = acc_q;
    omax_d       = omax_q;
    omax_valid_d = 1'b0;
    frame_seen_d = frame_seen_q;
    if (v1_q) begin
      if (sof1_q) begin
        acc_d = mag_d;
        if (frame_seen_q) begin
          omax_d       = acc_q;
          omax_valid_d = 1'b1;
        end else begin
          frame_seen_d = 1'b1;
        end
      end else begin
        for (int unsigned k = 0; k < L; k++) begin
          if (mag_d[k*PIX_W +: PIX_W] > acc_q[k*PIX_W +: PIX_W])
            acc_d[k*PIX_W +: PIX_W] = mag_d[k*PIX_W +: PIX_W];
        end
      end
    end
  end

  // Frame statistics registers
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      acc_q        <= '0;
      omax_q       <= '0;
      omax_valid_q <= 1'b0;
      frame_seen_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      omax_q       <= omax_d;
      omax_valid_q <= omax_valid_d;
      frame_seen_q <= frame_seen_d;
    end
  end

  assign ovalid     = ovalid_q;
  assign odata      = odata_q;
  assign osb        = osb_q;
  assign osof       = osof_q;
  assign omax       = omax_q;
  assign omax_valid = omax_valid_q;

endmodule

// File: tb/tb_dog_pyramid_diff.sv
// Bench for dog_pyramid_diff (PIX_W=8, NUM_SCALES=5, SB_W=1): table vectors,
// hand-written frame/reset sequences and random traffic against a model.
module tb_dog_pyramid_diff;

  localparam int PW  = 8;
  localparam int NS  = 5;
  localparam int SBW = 1;
  localparam int L   = NS - 1;
  localparam int LW  = PW + 1;

  logic              clk = 1'b0;
  logic              irst_n = 1'b0;
  logic              ivalid = 1'b0;
  logic [NS*PW-1:0]  idata = '0;
  logic [SBW-1:0]    isb = '0;
  logic              isof = 1'b0;
  logic [1:0]        imode = '0;
  logic              ovalid;
  logic [L*LW-1:0]   odata;
  logic [SBW-1:0]    osb;
  logic              osof;
  logic [L*PW-1:0]   omax;
  logic              omax_valid;

  dog_pyramid_diff #(.PIX_W(PW), .NUM_SCALES(NS), .SB_W(SBW)) dut (
    .clk(clk), .irst_n(irst_n), .ivalid(ivalid), .idata(idata), .isb(isb),
    .isof(isof), .imode(imode), .ovalid(ovalid), .odata(odata), .osb(osb),
    .osof(osof), .omax(omax), .omax_valid(omax_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             v;
    logic [NS*PW-1:0] d;
    logic             sb;
    logic             sof;
    logic [1:0]       mode;
  } pend_t;

  typedef struct {
    logic [NS*PW-1:0] d;
    logic [1:0]       mode;
    logic [L*LW-1:0]  exp;
  } vec_t;

  pend_t           pq[$];
  logic            exp_ovalid;
  logic [L*LW-1:0] exp_odata;
  logic            exp_osb;
  logic            exp_osof;
  logic [L*PW-1:0] exp_omax;
  logic            exp_omax_valid;
  int              run_max[L];
  bit              seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NS*PW-1:0] pack5(input int g0, input int g1, input int g2,
                                             input int g3, input int g4);
    logic [NS*PW-1:0] r;
    r = {g4[7:0], g3[7:0], g2[7:0], g1[7:0], g0[7:0]};
    return r;
  endfunction

  function automatic logic [L*LW-1:0] lanes4(input int l0, input int l1, input int l2, input int l3);
    logic [L*LW-1:0] r;
    r = {l3[8:0], l2[8:0], l1[8:0], l0[8:0]};
    return r;
  endfunction

  task automatic model_reset();
    pend_t z;
    z.v = 1'b0; z.d = '0; z.sb = 1'b0; z.sof = 1'b0; z.mode = '0;
    pq.delete();
    pq.push_back(z);
    pq.push_back(z);
    exp_ovalid = 0; exp_odata = '0; exp_osb = 0; exp_osof = 0;
    exp_omax = '0; exp_omax_valid = 0; seen = 0;
    for (int k = 0; k < L; k++) run_max[k] = 0;
  endtask

  // Expected outputs for one pixel, from the arithmetic definition of DoG
  task automatic model_apply(input pend_t p);
    int a, b, d, lane, t;
    int mag[L];
    if (!p.v) begin
      exp_ovalid     = 1'b0;
      exp_omax_valid = 1'b0;
      return;
    end
    for (int k = 0; k < L; k++) begin
      a = int'(p.d[k*PW +: PW]);
      b = int'(p.d[(k+1)*PW +: PW]);
      d = a - b;
      case (p.mode)
        2'd1:    lane = (d < 0) ? -d : d;
        2'd2:    lane = d;
        default: lane = (d > 0) ? d : 0;
      endcase
      mag[k] = (p.mode == 2'd1 || p.mode == 2'd2) ? ((d < 0) ? -d : d) : ((d > 0) ? d : 0);
      exp_odata[k*LW +: LW] = lane[8:0];
    end
    exp_ovalid = 1'b1;
    exp_osb    = p.sb;
    exp_osof   = p.sof;
    exp_omax_valid = 1'b0;
    if (p.sof) begin
      if (seen) begin
        for (int k = 0; k < L; k++) begin
          t = run_max[k];
          exp_omax[k*PW +: PW] = t[7:0];
        end
        exp_omax_valid = 1'b1;
      end
      seen = 1;
      for (int k = 0; k < L; k++) run_max[k] = mag[k];
    end else begin
      for (int k = 0; k < L; k++) if (mag[k] > run_max[k]) run_max[k] = mag[k];
    end
  endtask

  task automatic check_all();
    check("ovalid", 64'(ovalid), 64'(exp_ovalid));
    check("odata", 64'(odata), 64'(exp_odata));
    check("osb", 64'(osb), 64'(exp_osb));
    check("osof", 64'(osof), 64'(exp_osof));
    check("omax", 64'(omax), 64'(exp_omax));
    check("omax_valid", 64'(omax_valid), 64'(exp_omax_valid));
  endtask

  // One cycle: check outputs for the pixel driven two cycles ago, drive next
  task automatic step(input logic v, input logic [NS*PW-1:0] d, input logic sb,
                      input logic sof, input logic [1:0] m);
    pend_t p;
    @(negedge clk);
    p = pq.pop_front();
    model_apply(p);
    check_all();
    ivalid = v; idata = d; isb = sb; isof = sof; imode = m;
    p.v = v; p.d = d; p.sb = sb; p.sof = sof; p.mode = m;
    pq.push_back(p);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 2'd0);
  endtask

  // Asynchronous reset in the middle of the low clock phase
  task automatic reset_async();
    @(negedge clk);
    #2;
    irst_n = 1'b0;
    ivalid = 1'b0;
    #1;
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_odata", 64'(odata), 64'd0);
    check("rst_osb", 64'(osb), 64'd0);
    check("rst_osof", 64'(osof), 64'd0);
    check("rst_omax", 64'(omax), 64'd0);
    check("rst_omax_valid", 64'(omax_valid), 64'd0);
    model_reset();
    @(negedge clk);
    irst_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [NS*PW-1:0] rd;
    int g[NS];

    tbl[0] = '{pack5(200, 50, 0, 0, 0), 2'd0, lanes4(150, 50, 0, 0)};
    tbl[1] = '{pack5(50, 200, 0, 0, 0), 2'd0, lanes4(0, 200, 0, 0)};
    tbl[2] = '{pack5(77, 77, 0, 0, 0), 2'd0, lanes4(0, 77, 0, 0)};
    tbl[3] = '{pack5(10, 250, 0, 0, 0), 2'd1, lanes4(240, 250, 0, 0)};
    tbl[4] = '{pack5(10, 250, 0, 0, 0), 2'd2, lanes4(-240, 250, 0, 0)};
    tbl[5] = '{pack5(10, 250, 0, 0, 0), 2'd3, lanes4(0, 250, 0, 0)};
    tbl[6] = '{pack5(100, 80, 80, 90, 0), 2'd2, lanes4(20, 0, -10, 90)};
    tbl[7] = '{pack5(100, 80, 80, 90, 0), 2'd0, lanes4(20, 0, 0, 90)};
    tbl[8] = '{pack5(0, 255, 0, 255, 0), 2'd2, lanes4(-255, 255, -255, 255)};
    tbl[9] = '{pack5(255, 0, 255, 0, 255), 2'd1, lanes4(255, 255, 255, 255)};

    model_reset();
    reset_async();

    // Table vectors, each followed by a gap so odata holds for a direct check
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].d, i[0], 1'b0, tbl[i].mode);
      idle();
      idle();
      check($sformatf("tbl%0d", i), 64'(odata), 64'(tbl[i].exp));
    end

    // Mode toggling every cycle with fixed data
    for (int i = 0; i < 8; i++)
      step(1'b1, pack5(10, 250, 0, 0, 0), 1'b0, 1'b0, i[0] ? 2'd2 : 2'd1);

    // Valid gaps: 1,0,0,1 with distinct data and sideband
    step(1'b1, pack5(1, 2, 3, 4, 5), 1'b1, 1'b0, 2'd2);
    step(1'b0, pack5(9, 9, 9, 9, 9), 1'b0, 1'b1, 2'd0);
    step(1'b0, pack5(8, 7, 6, 5, 4), 1'b0, 1'b1, 2'd0);
    step(1'b1, pack5(50, 40, 30, 20, 10), 1'b0, 1'b1, 2'd1);
    idle();
    idle();

    // Frame maximum across frames A, B, C
    reset_async();
    step(1'b1, pack5(5, 0, 0, 0, 0), 1'b0, 1'b1, 2'd0);
    step(1'b1, pack5(200, 0, 0, 0, 0), 1'b0, 1'b0, 2'd0);
    step(1'b1, pack5(17, 0, 0, 0, 0), 1'b0, 1'b0, 2'd0);
    check("A_nopulse", 64'(omax_valid), 64'd0);
    step(1'b1, pack5(3, 0, 0, 0, 0), 1'b1, 1'b1, 2'd0);
    step(1'b1, pack5(9, 0, 0, 0, 0), 1'b0, 1'b0, 2'd0);
    step(1'b1, pack5(1, 0, 0, 0, 0), 1'b0, 1'b1, 2'd0);
    check("B_pulse", 64'(omax_valid), 64'd1);
    check("B_max", 64'(omax[7:0]), 64'd200);
    check("B_osof", 64'(osof), 64'd1);
    idle();
    idle();
    check("C_pulse", 64'(omax_valid), 64'd1);
    check("C_max", 64'(omax[7:0]), 64'd9);
    idle();
    check("C_pulse_end", 64'(omax_valid), 64'd0);
    check("C_max_hold", 64'(omax[7:0]), 64'd9);

    // Reset mid-frame, then two frames
    step(1'b1, pack5(40, 0, 0, 0, 0), 1'b0, 1'b1, 2'd0);
    step(1'b1, pack5(60, 0, 0, 0, 0), 1'b0, 1'b0, 2'd0);
    reset_async();
    step(1'b1, pack5(30, 0, 0, 0, 0), 1'b0, 1'b1, 2'd1);
    step(1'b1, pack5(0, 70, 0, 0, 0), 1'b0, 1'b0, 2'd2);
    step(1'b1, pack5(11, 0, 0, 0, 0), 1'b0, 1'b0, 2'd0);
    check("post_rst_nopulse", 64'(omax_valid), 64'd0);
    step(1'b1, pack5(2, 0, 0, 0, 0), 1'b0, 1'b1, 2'd0);
    idle();
    idle();
    check("post_rst_pulse", 64'(omax_valid), 64'd1);
    check("post_rst_max", 64'(omax[7:0]), 64'd70);

    // Back-to-back sof pixels: one-pixel frames
    for (int i = 0; i < 6; i++)
      step(1'b1, pack5(i * 40, 255 - i * 30, i, 0, 128), 1'b0, 1'b1, 2'(i % 4));

    // Random traffic including extreme pixel values
    for (int n = 0; n < 600; n++) begin
      for (int s = 0; s < NS; s++)
        g[s] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 255 : 0)
                                           : int'($urandom_range(0, 255));
      rd = pack5(g[0], g[1], g[2], g[3], g[4]);
      r = {$urandom, $urandom};
      step($urandom_range(0, 9) < 8, rd, r[0], $urandom_range(0, 99) < 15,
           2'($urandom_range(0, 3)));
    end
    idle();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dog_pyramid_diff.md
Name: dog_pyramid_diff

Overview:
Parametrised difference-of-Gaussian stage for the SIFT detection pipeline. It takes NUM_SCALES co-located Gaussian-blurred pixels per cycle and produces NUM_SCALES-1 DoG lanes with a selectable output mode. It carries a valid qualifier and sideband bits through a fixed 2-cycle pipeline. It also tracks a per-lane, per-frame maximum DoG magnitude for downstream threshold tuning. It sits between the Gaussian blur bank and the extrema detector.

Parameters:
PIX_W, 8, bits per Gaussian pixel
NUM_SCALES, 5, Gaussian scales per pixel (>=2); number of lanes L = NUM_SCALES-1
SB_W, 1, sideband bits passed through unchanged

Ports:
clk  input  1  clock
irst_n  input  1  asynchronous active-low reset
ivalid  input  1  input pixel qualifier
idata  input  NUM_SCALES*PIX_W  scale s occupies bits [s*PIX_W +: PIX_W]; s=0 is least blurred
isb  input  SB_W  sideband (e.g. border flag)
isof  input  1  start of frame; meaningful only with ivalid
imode  input  2  0=clamp-to-zero, 1=absolute, 2=signed, 3=reserved (behaves as 0)
ovalid  output  1  output qualifier
odata  output  L*(PIX_W+1)  lane k occupies bits [k*(PIX_W+1) +: PIX_W+1]
osb  output  SB_W  sideband aligned with odata
osof  output  1  isof aligned with odata
omax  output  L*PIX_W  previous frame max magnitude per lane, bits [k*PIX_W +: PIX_W]
omax_valid  output  1  one-cycle pulse when omax updates

Behaviour:
- Reset: clk and irst_n, asynchronous active-low. All registers clear to 0: stage-1 data, sb, sof, mode and valid; odata, osb, osof, ovalid, omax, omax_valid; the running-max accumulators; the frame_seen flag.
- Stage 1 (cycle N+1): when ivalid=1, register idata, isb, isof and imode. v1 <= ivalid every cycle. When ivalid=0, the stage-1 data registers hold.
- Stage 2 (cycle N+2): when v1=1, compute every lane k as D = G[k] - G[k+1] at PIX_W+1 bits, two's complement. The result depends on the registered mode:
  - mode 0 or 3: if G[k] > G[k+1], output D with MSB 0; otherwise output 0. Equal inputs give 0.
  - mode 1: output |D|, MSB 0.
  - mode 2: output D signed; range -(2^PIX_W-1) .. +(2^PIX_W-1).
- ovalid <= v1. osb and osof register in step with odata.
- When v1=0, odata, osb and osof hold their last values and ovalid=0.
- Latency is exactly 2 cycles for all modes. Throughput is 1 pixel per cycle. There is no backpressure.
- The mode is captured with its pixel. A mode change between pixels applies only to pixels sampled in the same cycle as the new imode.
- Magnitude M_k equals the mode-0 result in modes 0/3 and |D| in modes 1/2. M_k fits PIX_W bits because max |D| = 2^PIX_W-1.
- Frame statistics, updated on cycles with v1=1:
  - If the stage-1 sof bit is 1 and frame_seen=1: omax <= acc, omax_valid <= 1, acc_k <= M_k of the current pixel.
  - If the stage-1 sof bit is 1 and frame_seen=0: set frame_seen, acc_k <= M_k, no pulse.
  - Otherwise: acc_k <= max(acc_k, M_k).
- omax_valid is high for exactly one cycle, coincident with ovalid/osof of the first pixel of the new frame. omax holds between pulses.
- Pixels before the first sof after reset accumulate into acc, but that accumulation is discarded at the first sof.
- Reset mid-frame clears all state. The next sof produces no omax pulse.
- Back-to-back sof pixels (a one-pixel frame) produce a pulse each cycle. Each pulse reports only the previous pixel's M.
- The sideband is opaque and never affects the arithmetic.

Test Plan:
1. Legacy equivalence: PIX_W=8, NUM_SCALES=2, mode 0. Inputs G0=200, G1=50 -> two cycles later lane0=150, ovalid=1. Inputs G0=50, G1=200 -> lane0=0. Inputs G0=G1=77 -> lane0=0.
2. Modes: G0=10, G1=250. Mode 1 -> lane0=240 (9'h0F0). Mode 2 -> lane0=-240 (9'h110). Mode 3 -> lane0=0. Toggle imode each cycle with fixed data -> outputs alternate in lockstep 2 cycles later.
3. Multi-lane: NUM_SCALES=5, G={100,80,80,90,0}, s0 first, mode 2 -> lanes {+20, 0, -10, +90}. Mode 0 -> lanes {20, 0, 0, 90}.
4. Valid gaps: drive ivalid 1,0,0,1 with distinct data -> ovalid 1,0,0,1 delayed 2 cycles; odata holds through the gap; osb and osof stay aligned.
5. Frame max: after reset, frame A (sof on pixel 0; lane0 magnitudes 5, 200, 17) produces no pulse. Frame B sof pixel -> omax lane0=200 and omax_valid pulses for 1 cycle, aligned with osof. Frame B magnitudes 3, 9; frame C sof -> omax lane0=9.
6. Reset mid-frame: assert irst_n=0 during frame B -> all outputs 0 asynchronously. After release, the first sof gives no pulse and the second sof reports the max of the frame between them.
